hazard_scoreboard: RTL and testbench

Parametrised hazard unit for the in-order LoongArch pipeline: it sits beside the ID stage and tracks every in-flight register writer in a shadow tracker (EX..WB), plus one outstanding multicycle (mul/div) writer. It decides ID stall/bubble insertion per operand, using operand-class-dependent ready stages (ALU, load, CSR, early branch-compare use). It also produces the prioritised per-stage flush vector for exceptions, ertn, refetch and branch redirect.

---
 rtl/hazard_scoreboard.sv | 159 +++++++++++++++
 tb/tb_hazard_scoreboard.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: shadow tracker of in-flight writers (EX..WB),
// multicycle-writer scoreboard, stall/bubble control and flush priority.
module hazard_scoreboard #(
    parameter int NSRC    = 3,
    parameter int STAGES  = 3,
    parameter int ALU_RDY = 1,
    parameter int LD_RDY  = 2,
    parameter int CSR_RDY = 3,
    parameter int CNT_W   = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  id_valid,
    input  logic [NSRC-1:0][4:0]  id_src_no,
    input  logic [NSRC-1:0]       id_src_used,
    input  logic                  id_early,
    input  logic                  id_wen,
    input  logic [4:0]            id_dst_no,
    input  logic [1:0]            id_kind,
    input  logic                  branch_taken,
    input  logic                  mc_done,
    input  logic                  flush_mem,
    input  logic                  flush_wb,
    output logic                  id_ready,
    output logic                  if_flush,
    output logic                  id_flush,
    output logic                  ex_flush,
    output logic                  mem_flush,
    output logic                  wb_flush,
    output logic                  mc_abort,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam logic [1:0] K_LD  = 2'd1;
    localparam logic [1:0] K_CSR = 2'd2;
    localparam logic [1:0] K_MC  = 2'd3;

    logic [STAGES:1]      r_vld;
    logic [STAGES:1][4:0] r_dst;
    logic [STAGES:1][1:0] r_kind;
    logic                 r_mc_busy;
    logic [4:0]           r_mc_dst;
    logic [CNT_W-1:0]     r_cnt;

    logic w_op_haz;
    logic w_mc_src;
    logic w_mc_haz;
    logic w_stall;
    logic w_flush;
    logic w_issue;
    logic w_trk_in;

    function automatic int rdy_stage(input logic [1:0] k);
        case (k)
            K_LD:    return LD_RDY;
            K_CSR:   return CSR_RDY;
            default: return ALU_RDY;
        endcase
    endfunction

    // A writer is still unforwardable while it sits before its ready stage;
    // operands consumed in ID need the value one stage earlier.
    always_comb begin
        w_op_haz = 1'b0;
        w_mc_src = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (id_src_used[i] && id_src_no[i] != 5'd0) begin
                for (int s = 1; s <= STAGES; s++) begin
                    if (r_vld[s] && r_dst[s] == id_src_no[i] &&
                        s < rdy_stage(r_kind[s]) + (id_early ? 1 : 0))
                        w_op_haz = 1'b1;
                end
                if (id_src_no[i] == r_mc_dst)
                    w_mc_src = 1'b1;
            end
        end
    end

    assign w_mc_haz = r_mc_busy & ~mc_done &
                      (w_mc_src | (id_kind == K_MC));
    assign w_stall  = id_valid & (w_op_haz | w_mc_haz);
    assign w_flush  = flush_mem | flush_wb;

    always_comb begin
        id_ready  = 1'b1;
        if_flush  = 1'b0;
        id_flush  = 1'b0;
        ex_flush  = 1'b0;
        mem_flush = 1'b0;
        wb_flush  = 1'b0;
        if (flush_wb) begin
            id_ready  = 1'b0;
            if_flush  = 1'b1;
            id_flush  = 1'b1;
            ex_flush  = 1'b1;
            mem_flush = 1'b1;
            wb_flush  = 1'b1;
        end else if (flush_mem) begin
            id_ready  = 1'b0;
            if_flush  = 1'b1;
            id_flush  = 1'b1;
            ex_flush  = 1'b1;
            mem_flush = 1'b1;
        end else if (w_stall) begin
            id_ready  = 1'b0;
            ex_flush  = 1'b1;
        end else if (branch_taken) begin
            id_flush  = 1'b1;
        end
    end

    assign mc_abort  = w_flush & r_mc_busy;
    assign stall_cnt = r_cnt;
    assign w_issue   = id_valid & id_ready;
    assign w_trk_in  = w_issue & id_wen & (id_dst_no != 5'd0) &
                       (id_kind != K_MC);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld  <= '0;
            r_dst  <= '0;
            r_kind <= '0;
        end else if (flush_wb) begin
            r_vld  <= '0;
        end else begin
            r_vld[1]  <= w_trk_in & ~flush_mem;
            r_dst[1]  <= id_dst_no;
            r_kind[1] <= id_kind;
            for (int s = 2; s <= STAGES; s++) begin
                r_vld[s]  <= (flush_mem && s <= 2) ? 1'b0 : r_vld[s-1];
                r_dst[s]  <= r_dst[s-1];
                r_kind[s] <= r_kind[s-1];
            end
        end
    end

    // An aborted op never reports mc_done, so any flush frees the unit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mc_busy <= 1'b0;
            r_mc_dst  <= 5'd0;
        end else if (w_flush) begin
            r_mc_busy <= 1'b0;
        end else if (w_issue && id_kind == K_MC) begin
            r_mc_busy <= 1'b1;
            r_mc_dst  <= id_wen ? id_dst_no : 5'd0;
        end else if (mc_done) begin
            r_mc_busy <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_cnt <= '0;
        else if (w_stall && !w_flush && r_cnt != '1)
            r_cnt <= r_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (CNT_W=4 build for saturation).
module tb_hazard_scoreboard;

    logic           clk;
    logic           rstn;
    logic           id_valid;
    logic [2:0][4:0] id_src_no;
    logic [2:0]     id_src_used;
    logic           id_early;
    logic           id_wen;
    logic [4:0]     id_dst_no;
    logic [1:0]     id_kind;
    logic           branch_taken;
    logic           mc_done;
    logic           flush_mem;
    logic           flush_wb;
    logic           id_ready;
    logic           if_flush;
    logic           id_flush;
    logic           ex_flush;
    logic           mem_flush;
    logic           wb_flush;
    logic           mc_abort;
    logic [3:0]     stall_cnt;
    logic [4:0]     fl;

    int n_chk = 0;
    int n_err = 0;

    hazard_scoreboard #(.CNT_W(4)) dut (
        .clk(clk), .rstn(rstn), .id_valid(id_valid),
        .id_src_no(id_src_no), .id_src_used(id_src_used),
        .id_early(id_early), .id_wen(id_wen), .id_dst_no(id_dst_no),
        .id_kind(id_kind), .branch_taken(branch_taken),
        .mc_done(mc_done), .flush_mem(flush_mem), .flush_wb(flush_wb),
        .id_ready(id_ready), .if_flush(if_flush), .id_flush(id_flush),
        .ex_flush(ex_flush), .mem_flush(mem_flush), .wb_flush(wb_flush),
        .mc_abort(mc_abort), .stall_cnt(stall_cnt)
    );

    assign fl = {if_flush, id_flush, ex_flush, mem_flush, wb_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [4:0] s0,
                       input logic [4:0] s1, input logic [2:0] used,
                       input logic early, input logic wen,
                       input logic [4:0] dst, input logic [1:0] kind);
        id_valid     = v;
        id_src_no[0] = s0;
        id_src_no[1] = s1;
        id_src_no[2] = 5'd0;
        id_src_used  = used;
        id_early     = early;
        id_wen       = wen;
        id_dst_no    = dst;
        id_kind      = kind;
        branch_taken = 1'b0;
        mc_done      = 1'b0;
        flush_mem    = 1'b0;
        flush_wb     = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        drv(0, 0, 0, 3'b000, 0, 0, 0, 0);
        #2;
        chk("rst_ready", id_ready, 1);
        chk("rst_flush", fl, 5'b00000);
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_abort", mc_abort, 0);
        @(negedge clk); rstn = 1'b1;

        // load r5, then consumer of r5
        @(negedge clk); drv(1, 0, 0, 3'b000, 0, 1, 5, 1); #1;
        chk("ld_issue_ready", id_ready, 1);
        @(negedge clk); drv(1, 5, 0, 3'b001, 0, 1, 6, 0); #1;
        chk("ld_use_ready", id_ready, 0);
        chk("ld_use_flush", fl, 5'b00100);
        chk("ld_use_cnt0", stall_cnt, 0);
        @(negedge clk); #1;
        chk("ld_use_ready2", id_ready, 1);
        chk("ld_use_cnt1", stall_cnt, 1);

        // ALU r7 then early branch on r7
        @(negedge clk); drv(1, 0, 0, 3'b000, 0, 1, 7, 0); #1;
        @(negedge clk); drv(1, 7, 0, 3'b001, 1, 0, 0, 0);
        branch_taken = 1'b1; #1;
        chk("alu_br_ready", id_ready, 0);
        chk("alu_br_flush", fl, 5'b00100);
        @(negedge clk); #1;
        chk("alu_br_ready2", id_ready, 1);
        chk("alu_br_idflush", fl, 5'b01000);
        chk("alu_br_cnt", stall_cnt, 2);

        // load r8 then early branch on r8: two stalls
        @(negedge clk); drv(1, 0, 0, 3'b000, 0, 1, 8, 1); #1;
        @(negedge clk); drv(1, 8, 0, 3'b001, 1, 0, 0, 0); #1;
        chk("ld_br_s1", id_ready, 0);
        @(negedge clk); #1;
        chk("ld_br_s2", id_ready, 0);
        @(negedge clk); #1;
        chk("ld_br_go", id_ready, 1);
        chk("ld_br_cnt", stall_cnt, 4);

        // div r9, consumer waits for mc_done
        @(negedge clk); drv(1, 0, 0, 3'b000, 0, 1, 9, 3); #1;
        chk("div_issue", id_ready, 1);
        @(negedge clk); drv(1, 0, 9, 3'b010, 0, 1, 10, 0); #1;
        chk("div_use_stall", id_ready, 0);
        @(negedge clk); mc_done = 1'b1; #1;
        chk("div_done_ready", id_ready, 1);
        @(negedge clk); drv(1, 0, 0, 3'b000, 0, 1, 11, 3); #1;
        chk("div2_issue", id_ready, 1);
        @(negedge clk); drv(1, 0, 0, 3'b000, 0, 1, 12, 3); #1;
        chk("div_busy_stall", id_ready, 0);
        chk("div_busy_cnt", stall_cnt, 5);
        @(negedge clk); mc_done = 1'b1; #1;
        chk("div_done_issue", id_ready, 1);
        chk("div_done_cnt", stall_cnt, 6);

        // flush_wb with stall and branch on r12 (busy)
        @(negedge clk); drv(1, 12, 0, 3'b001, 0, 0, 0, 0);
        branch_taken = 1'b1; flush_wb = 1'b1; #1;
        chk("fwb_flush", fl, 5'b11111);
        chk("fwb_ready", id_ready, 0);
        chk("fwb_abort", mc_abort, 1);
        @(negedge clk); drv(1, 12, 10, 3'b011, 0, 1, 13, 2); #1;
        chk("fwb_empty_ready", id_ready, 1);
        chk("fwb_cnt", stall_cnt, 6);
        chk("fwb_abort_off", mc_abort, 0);
        chk("fwb_flush_off", fl, 5'b00000);

        // CSR r13 at stage 2 survives flush_mem into stage 3
        @(negedge clk); drv(0, 0, 0, 3'b000, 0, 0, 0, 0); #1;
        chk("idle_ready", id_ready, 1);
        @(negedge clk); drv(1, 13, 0, 3'b001, 0, 0, 0, 0);
        flush_mem = 1'b1; #1;
        chk("fmem_flush", fl, 5'b11110);
        chk("fmem_ready", id_ready, 0);
        chk("fmem_abort", mc_abort, 0);
        @(negedge clk); drv(1, 13, 0, 3'b001, 0, 0, 0, 0); #1;
        chk("fmem_csr_norm", id_ready, 1);
        chk("fmem_cnt", stall_cnt, 6);
        id_early = 1'b1; #1;
        chk("fmem_csr_early", id_ready, 0);
        chk("fmem_csr_bub", fl, 5'b00100);
        @(negedge clk); drv(0, 0, 0, 3'b000, 0, 0, 0, 0); #1;
        chk("csr_cnt", stall_cnt, 7);

        // r0 never hazards
        @(negedge clk); drv(1, 0, 0, 3'b000, 0, 1, 0, 1); #1;
        @(negedge clk); drv(1, 0, 0, 3'b011, 0, 0, 0, 0); #1;
        chk("r0_ready", id_ready, 1);

        // saturation: stall for 2^4+3 cycles behind a div
        @(negedge clk); drv(1, 0, 0, 3'b000, 0, 1, 14, 3); #1;
        @(negedge clk); drv(1, 14, 0, 3'b001, 0, 0, 0, 0); #1;
        chk("sat_stall", id_ready, 0);
        for (int k = 0; k < 18; k++) @(negedge clk);
        #1;
        chk("sat_cnt", stall_cnt, 15);
        @(negedge clk); #1;
        chk("sat_hold", stall_cnt, 15);
        mc_done = 1'b1; #1;
        chk("sat_done_ready", id_ready, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
